// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the MIPS core blocks.
//   WORD_W      : architectural word width (HI/LO, operands).
//   muldiv_op_t : MULT/MULTU/DIV/DIVU encodings as sampled from the E stage.
//   md_state_t  : states of the iterative multiply/divide unit.
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } md_state_t;

endpackage

// File: rtl/mips_negate.sv
// -----------------------------------------------------------------------------
// mips_negate
// Conditional two's-complement. Used both to take operand magnitudes and to
// re-apply signs to the product / quotient / remainder.
//   i_val : value to (optionally) negate
//   i_neg : 1 -> output is -i_val, 0 -> output is i_val
//   o_val : result
// -----------------------------------------------------------------------------
module mips_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? ({W{1'b0}} - i_val) : i_val;

endmodule

// File: rtl/mips_muldiv.sv
// -----------------------------------------------------------------------------
// mips_muldiv
// Iterative multiply/divide unit beside the execute stage. Owns HI/LO.
// One bit per cycle for WIDTH cycles (shift-add multiply or restoring divide),
// followed by one sign-fixup cycle that writes HI/LO.
//
// Handshake: i_start is a single-cycle launch request, accepted only in IDLE
// and only when i_cancel is low; o_busy is high in every cycle the unit is not
// IDLE, and the issuing logic must hold off further mfhi/mflo/muldiv while it
// is high (a start seen while busy is dropped). o_done pulses for one cycle
// right after HI/LO were written; a new start in that same cycle is accepted.
//
// Ports:
//   i_clk, i_reset : clock (rising edge), asynchronous active-high reset
//   i_start        : launch request
//   i_op           : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   i_srca, i_srcb : rs / rt operands
//   i_cancel       : abort in-flight operation, HI/LO untouched
//   o_busy, o_done : status
//   o_hi, o_lo     : HI/LO registers
//   o_state        : FSM state, for observation
// -----------------------------------------------------------------------------
module mips_muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int CNT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_srca,
    input  logic [WIDTH-1:0] i_srcb,
    input  logic             i_cancel,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output md_state_t        o_state
);

    md_state_t        r_state;
    md_state_t        w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic             r_neg_res;   // sign(a)^sign(b) for signed ops
    logic             r_neg_rem;   // remainder follows dividend sign
    logic             r_div0;
    logic [WIDTH-1:0] r_orig_a;    // kept for the divide-by-zero HI value
    logic [WIDTH-1:0] r_b;         // multiplicand / divisor magnitude
    logic [WIDTH-1:0] r_acc;       // product high half / partial remainder
    logic [WIDTH-1:0] r_mplr;      // multiplier / dividend-then-quotient
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic             w_load;
    logic             w_step;
    logic             w_fix;

    muldiv_op_t       w_op;
    logic             w_signed;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_op     = muldiv_op_t'(i_op);
    assign w_signed = (w_op == MD_MULT) || (w_op == MD_DIV);
    assign w_neg_a  = w_signed & i_srca[WIDTH-1];
    assign w_neg_b  = w_signed & i_srcb[WIDTH-1];

    // 0x80000000 negates to itself, which is exactly its unsigned magnitude.
    mips_negate #(.W(WIDTH)) u_neg_a (.i_val(i_srca), .i_neg(w_neg_a), .o_val(w_mag_a));
    mips_negate #(.W(WIDTH)) u_neg_b (.i_val(i_srcb), .i_neg(w_neg_b), .o_val(w_mag_b));

    // Multiply step: add multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole {acc,mplr} pair right.
    assign w_sum = {1'b0, r_acc} + (r_mplr[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});

    // Divide step: bring the next dividend bit into the remainder and try the
    // subtraction. Both the kept remainder and a successful difference are
    // below the divisor, so WIDTH bits hold them.
    assign w_shift = {r_acc, r_mplr[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_b});
    assign w_diff  = w_shift[WIDTH-1:0] - r_b;

    mips_negate #(.W(2*WIDTH)) u_neg_prod (.i_val({r_acc, r_mplr}), .i_neg(r_neg_res), .o_val(w_prod_fix));
    mips_negate #(.W(WIDTH))   u_neg_quo  (.i_val(r_mplr), .i_neg(r_neg_res), .o_val(w_quo_fix));
    mips_negate #(.W(WIDTH))   u_neg_rem  (.i_val(r_acc),  .i_neg(r_neg_rem), .o_val(w_rem_fix));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_fix        = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start && !i_cancel) begin
                    w_load       = 1'b1;
                    w_next_state = CALC;
                end
            end
            CALC: begin
                if (i_cancel) begin
                    w_next_state = IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == '0) w_next_state = FIX;
                end
            end
            FIX: begin
                w_next_state = IDLE;
                w_fix        = !i_cancel;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            r_orig_a  <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_mplr    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_fix;
            if (w_load) begin
                r_cnt     <= CNT_W'(WIDTH - 1);
                r_is_div  <= i_op[1];
                r_neg_res <= w_neg_a ^ w_neg_b;
                r_neg_rem <= w_neg_a;
                r_div0    <= (i_srcb == '0);
                r_orig_a  <= i_srca;
                r_b       <= w_mag_b;
                r_acc     <= '0;
                r_mplr    <= w_mag_a;
            end
            if (w_step) begin
                if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                if (r_is_div) begin
                    r_acc  <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                    r_mplr <= {r_mplr[WIDTH-2:0], w_ge};
                end else begin
                    {r_acc, r_mplr} <= {w_sum, r_mplr[WIDTH-1:1]};
                end
            end
            if (w_fix) begin
                if (!r_is_div) begin
                    {r_hi, r_lo} <= w_prod_fix;
                end else if (r_div0) begin
                    r_hi <= r_orig_a;
                    r_lo <= {WIDTH{1'b1}};
                end else begin
                    r_hi <= w_rem_fix;
                    r_lo <= w_quo_fix;
                end
            end
        end
    end

    assign o_busy  = (r_state != IDLE);
    assign o_done  = r_done;
    assign o_hi    = r_hi;
    assign o_lo    = r_lo;
    assign o_state = r_state;

endmodule
